mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 CLK  in  1  sole clock; all state rising-edge.
REQ-002 RST  in  1  reset, asynchronous, active-high.
REQ-003 en  in  1  pipeline advance enable from hazard unit.
REQ-004 flush  in  1  squash current MEM contents.
REQ-005 port_out_i  in  32  ALU result / memory byte address.
REQ-006 rdat2_i  in  32  store data.
REQ-007 rd_i  in  5; regWr_i, dREN_i, dWEN_i, halt_i  in  1  each  EX/MEM control.
REQ-008 func3_i  in  3  load size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-009 rdSel_i  in  3  writeback select; npc_i, imm_i  in  32  alternate writeback sources.
REQ-010 dhit  in  1; dmemload  in  32  data cache response.
REQ-011 dmemREN, dmemWEN  out  1; dmemaddr, dmemstore  out  32  data cache request.
REQ-012 mem_stall  out  1  freeze upstream stages.
REQ-013 regWr_o  out  1; rd_o  out  5; wdat_o  out  32; halt_o  out  1  MEM/WB register outputs.

Function
REQ-014 FSM states SHALL be IDLE, BUSY, HELD.
REQ-015 mem op = (dREN_i|dWEN_i) & ~flush; dREN_i and dWEN_i both high SHALL be treated as a store.
REQ-016 dmemREN/dmemWEN SHALL follow dREN_i/dWEN_i combinationally in IDLE and BUSY, and be 0 in HELD or when flush=1.
REQ-017 dmemaddr SHALL be {port_out_i[31:2],2'b00}; dmemstore = rdat2_i; stores SHALL be word-only, func3_i ignored.
REQ-018 IDLE: mem op & ~dhit -> BUSY; mem op & dhit & ~en -> HELD with dmemload captured into a 32-bit buffer; otherwise stay IDLE.
REQ-019 BUSY: dhit & en -> IDLE; dhit & ~en -> HELD (buffer captured); ~dhit -> BUSY.
REQ-020 HELD: en -> IDLE; ~en -> HELD; no new cache request SHALL be issued.
REQ-021 mem_stall SHALL be 1 exactly when a mem op is requested and dhit=0 (IDLE or BUSY); 0 in HELD.
REQ-022 Load data source SHALL be dmemload in IDLE/BUSY, the buffer in HELD.
REQ-023 Load extraction SHALL use port_out_i[1:0] as byte offset (little-endian), port_out_i[1] as half offset; LB/LH sign-extend, LBU/LHU zero-extend, LW whole word; other func3 SHALL behave as LW.
REQ-024 wdat select: rdSel 0 port_out_i, 1 extracted load data, 2 npc_i, 3 imm_i, 4-7 port_out_i.
REQ-025 MEM/WB register SHALL load on en & ~mem_stall; hold otherwise.
REQ-026 flush SHALL have priority over en: registers load bubble (regWr_o=0, rd_o=0, wdat_o=0, halt_o unchanged), FSM -> IDLE, buffer cleared.
REQ-027 halt_o SHALL be sticky: set when a non-flushed halt_i is latched, cleared only by reset.
REQ-028 Loads to rd_i=0 SHALL still access memory; regWr_o SHALL be forced 0 when rd_i=0.
REQ-029 Latency: a hit in the cycle of issue SHALL complete in 1 cycle (wdat_o valid after next edge); each miss cycle adds one stall cycle.

Reset
REQ-030 On RST: FSM IDLE, buffer 0, regWr_o 0, rd_o 0, wdat_o 0, halt_o 0.
REQ-031 RST mid-BUSY SHALL drop the request combinationally (dmemREN/dmemWEN 0 while RST high) and abandon the access.

Structure
REQ-032 FSM state enum and rdSel encodings SHALL live in cpu_types_pkg; word_t, regbits_t reused from it.
REQ-033 Load extraction SHALL be a combinational sub-module load_extend (data, offset, func3 -> word).

Verification
REQ-034 LW addr 0x100, dhit same cycle, en=1 -> mem_stall 0, wdat_o=dmemload next edge, FSM stays IDLE.
REQ-035 LB addr 0x103, dmemload 0x80FF_1234, dhit after 3 cycles -> mem_stall high 3 cycles, wdat_o=0xFFFF_FF80; LBU -> 0x0000_0080.
REQ-036 SW dhit while en=0 -> HELD, dmemWEN drops next cycle, single write only; en=1 -> IDLE.
REQ-037 flush asserted in BUSY -> request drops, next edge FSM IDLE, regWr_o=0.
REQ-038 halt_i latched then flush and further instructions -> halt_o remains 1 until RST.
REQ-039 RST asserted mid-BUSY -> all outputs reset values immediately, no request after release until new op.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word/register widths, MEM-stage FSM states,
// writeback-select and load-size encodings.
package cpu_types_pkg;

   typedef logic [31:0] word_t;
   typedef logic [4:0]  regbits_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      HELD = 2'd2
   } mem_state_t;

   localparam logic [2:0] RDSEL_ALU  = 3'd0;
   localparam logic [2:0] RDSEL_LOAD = 3'd1;
   localparam logic [2:0] RDSEL_NPC  = 3'd2;
   localparam logic [2:0] RDSEL_IMM  = 3'd3;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_extend.sv
// Little-endian byte/half/word extraction from a loaded word with sign or
// zero extension; unknown load sizes return the whole word.
module load_extend
   import cpu_types_pkg::*;
(
   input  logic [31:0] data,
   input  logic [1:0]  offset,
   input  logic [2:0]  func3,
   output logic [31:0] word
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   always_comb begin
      case (offset)
         2'd0:    byte_s = data[7:0];
         2'd1:    byte_s = data[15:8];
         2'd2:    byte_s = data[23:16];
         default: byte_s = data[31:24];
      endcase
      if (offset[1]) begin
         half_s = data[31:16];
      end else begin
         half_s = data[15:0];
      end
      case (func3)
         F3_LB:   word = {{24{byte_s[7]}}, byte_s};
         F3_LH:   word = {{16{half_s[15]}}, half_s};
         F3_LBU:  word = {24'd0, byte_s};
         F3_LHU:  word = {16'd0, half_s};
         default: word = data;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: drives the data-cache request, tracks miss/held state,
// extracts load data and holds the MEM/WB pipeline register.
module mem_stage
   import cpu_types_pkg::*;
(
   input  logic        CLK,
   input  logic        RST,
   input  logic        en,
   input  logic        flush,
   input  logic [31:0] port_out_i,
   input  logic [31:0] rdat2_i,
   input  logic [4:0]  rd_i,
   input  logic        regWr_i,
   input  logic        dREN_i,
   input  logic        dWEN_i,
   input  logic        halt_i,
   input  logic [2:0]  func3_i,
   input  logic [2:0]  rdSel_i,
   input  logic [31:0] npc_i,
   input  logic [31:0] imm_i,
   input  logic        dhit,
   input  logic [31:0] dmemload,
   output logic        dmemREN,
   output logic        dmemWEN,
   output logic [31:0] dmemaddr,
   output logic [31:0] dmemstore,
   output logic        mem_stall,
   output logic        regWr_o,
   output logic [4:0]  rd_o,
   output logic [31:0] wdat_o,
   output logic        halt_o
);

   mem_state_t state_r, next_state_s;
   word_t      buf_r;
   word_t      ld_src_s, ld_word_s, wdat_s;
   logic       mem_op_s, capture_s, advance_s;

   assign mem_op_s  = (dREN_i | dWEN_i) & ~flush;
   assign dmemaddr  = {port_out_i[31:2], 2'b00};
   assign dmemstore = rdat2_i;
   assign advance_s = en & ~mem_stall;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   always_comb begin
      next_state_s = state_r;
      if (flush) begin
         next_state_s = IDLE;
      end else begin
         case (state_r)
            IDLE: begin
               if (mem_op_s && !dhit)     next_state_s = BUSY;
               else if (mem_op_s && !en)  next_state_s = HELD;
               else                       next_state_s = IDLE;
            end
            BUSY: begin
               if (!mem_op_s)             next_state_s = IDLE;
               else if (!dhit)            next_state_s = BUSY;
               else if (en)               next_state_s = IDLE;
               else                       next_state_s = HELD;
            end
            HELD: begin
               if (en) next_state_s = IDLE;
               else    next_state_s = HELD;
            end
            default: next_state_s = IDLE;
         endcase
      end
   end

   // Request gating: RST and flush kill the request combinationally; a store wins over a load.
   always_comb begin
      dmemREN   = 1'b0;
      dmemWEN   = 1'b0;
      mem_stall = 1'b0;
      capture_s = 1'b0;
      ld_src_s  = dmemload;
      case (state_r)
         IDLE, BUSY: begin
            dmemWEN   = dWEN_i & ~flush & ~RST;
            dmemREN   = dREN_i & ~dWEN_i & ~flush & ~RST;
            mem_stall = mem_op_s & ~dhit & ~RST;
            capture_s = mem_op_s & dhit & ~en;
         end
         HELD: begin
            ld_src_s = buf_r;
         end
         default: begin
            ld_src_s = dmemload;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         buf_r <= 32'd0;
      end else if (flush) begin
         buf_r <= 32'd0;
      end else if (capture_s) begin
         buf_r <= dmemload;
      end else begin
         buf_r <= buf_r;
      end
   end

   load_extend u_load_extend (
      .data   (ld_src_s),
      .offset (port_out_i[1:0]),
      .func3  (func3_i),
      .word   (ld_word_s)
   );

   always_comb begin
      case (rdSel_i)
         RDSEL_LOAD: wdat_s = ld_word_s;
         RDSEL_NPC:  wdat_s = npc_i;
         RDSEL_IMM:  wdat_s = imm_i;
         default:    wdat_s = port_out_i;
      endcase
   end

   // MEM/WB register: flush inserts a bubble but never clears the sticky halt.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         regWr_o <= 1'b0;
         rd_o    <= 5'd0;
         wdat_o  <= 32'd0;
         halt_o  <= 1'b0;
      end else if (flush) begin
         regWr_o <= 1'b0;
         rd_o    <= 5'd0;
         wdat_o  <= 32'd0;
         halt_o  <= halt_o;
      end else if (advance_s) begin
         regWr_o <= regWr_i & (rd_i != 5'd0);
         rd_o    <= rd_i;
         wdat_o  <= wdat_s;
         halt_o  <= halt_o | halt_i;
      end else begin
         regWr_o <= regWr_o;
         rd_o    <= rd_o;
         wdat_o  <= wdat_o;
         halt_o  <= halt_o;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: table of single-cycle hit vectors checked
// through a scoreboard queue, plus hand sequences for miss/held/flush/halt/reset.
module tb_mem_stage;

   logic        CLK, RST, en, flush;
   logic [31:0] port_out_i, rdat2_i, npc_i, imm_i, dmemload;
   logic [4:0]  rd_i;
   logic        regWr_i, dREN_i, dWEN_i, halt_i, dhit;
   logic [2:0]  func3_i, rdSel_i;
   logic        dmemREN, dmemWEN, mem_stall, regWr_o, halt_o;
   logic [31:0] dmemaddr, dmemstore, wdat_o;
   logic [4:0]  rd_o;

   int passed = 0;
   int total  = 0;

   typedef struct {
      logic [2:0]  func3;
      logic [31:0] addr;
      logic [31:0] load;
      logic [2:0]  rdsel;
      logic [4:0]  rd;
      logic        regwr;
      logic        ren;
      logic [31:0] exp_wdat;
      logic        exp_regwr;
   } vec_t;

   localparam int NV = 16;
   vec_t        tbl [NV];
   logic [37:0] sb [$];
   logic [37:0] e;

   mem_stage dut (
      .CLK(CLK), .RST(RST), .en(en), .flush(flush),
      .port_out_i(port_out_i), .rdat2_i(rdat2_i), .rd_i(rd_i),
      .regWr_i(regWr_i), .dREN_i(dREN_i), .dWEN_i(dWEN_i), .halt_i(halt_i),
      .func3_i(func3_i), .rdSel_i(rdSel_i), .npc_i(npc_i), .imm_i(imm_i),
      .dhit(dhit), .dmemload(dmemload),
      .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
      .dmemstore(dmemstore), .mem_stall(mem_stall),
      .regWr_o(regWr_o), .rd_o(rd_o), .wdat_o(wdat_o), .halt_o(halt_o)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
      else passed++;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_in();
      en = 1'b1; flush = 1'b0; port_out_i = 32'd0; rdat2_i = 32'd0;
      rd_i = 5'd0; regWr_i = 1'b0; dREN_i = 1'b0; dWEN_i = 1'b0;
      halt_i = 1'b0; func3_i = 3'b010; rdSel_i = 3'd0;
      npc_i = 32'h0000_0444; imm_i = 32'hFFFF_F000; dhit = 1'b0; dmemload = 32'd0;
   endtask

   function automatic vec_t mk(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] ld,
                               input logic [2:0] rs, input logic [4:0] rd, input logic rw,
                               input logic rn, input logic [31:0] ew, input logic erw);
      vec_t v;
      v.func3 = f3; v.addr = a; v.load = ld; v.rdsel = rs; v.rd = rd;
      v.regwr = rw; v.ren = rn; v.exp_wdat = ew; v.exp_regwr = erw;
      return v;
   endfunction

   initial begin
      tbl[0]  = mk(3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 3'd1, 5'd5,  1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1);
      tbl[1]  = mk(3'b000, 32'h0000_0103, 32'h80FF_1234, 3'd1, 5'd6,  1'b1, 1'b1, 32'hFFFF_FF80, 1'b1);
      tbl[2]  = mk(3'b100, 32'h0000_0103, 32'h80FF_1234, 3'd1, 5'd6,  1'b1, 1'b1, 32'h0000_0080, 1'b1);
      tbl[3]  = mk(3'b000, 32'h0000_0101, 32'h80FF_1234, 3'd1, 5'd6,  1'b1, 1'b1, 32'h0000_0012, 1'b1);
      tbl[4]  = mk(3'b001, 32'h0000_0102, 32'h80FF_1234, 3'd1, 5'd8,  1'b1, 1'b1, 32'hFFFF_80FF, 1'b1);
      tbl[5]  = mk(3'b101, 32'h0000_0100, 32'h80FF_8234, 3'd1, 5'd8,  1'b1, 1'b1, 32'h0000_8234, 1'b1);
      tbl[6]  = mk(3'b001, 32'h0000_0100, 32'h80FF_8234, 3'd1, 5'd8,  1'b1, 1'b1, 32'hFFFF_8234, 1'b1);
      tbl[7]  = mk(3'b011, 32'h0000_0104, 32'h1234_5678, 3'd1, 5'd9,  1'b1, 1'b1, 32'h1234_5678, 1'b1);
      tbl[8]  = mk(3'b010, 32'hABCD_0001, 32'h0000_0000, 3'd0, 5'd10, 1'b1, 1'b0, 32'hABCD_0001, 1'b1);
      tbl[9]  = mk(3'b010, 32'h0000_0000, 32'h0000_0000, 3'd2, 5'd11, 1'b1, 1'b0, 32'h0000_0444, 1'b1);
      tbl[10] = mk(3'b010, 32'h0000_0000, 32'h0000_0000, 3'd3, 5'd12, 1'b1, 1'b0, 32'hFFFF_F000, 1'b1);
      tbl[11] = mk(3'b010, 32'h55AA_55AA, 32'h0000_0000, 3'd5, 5'd13, 1'b1, 1'b0, 32'h55AA_55AA, 1'b1);
      tbl[12] = mk(3'b010, 32'h0000_0108, 32'h0BAD_CAFE, 3'd1, 5'd0,  1'b1, 1'b1, 32'h0BAD_CAFE, 1'b0);
      tbl[13] = mk(3'b100, 32'h0000_0102, 32'h80FF_1234, 3'd1, 5'd14, 1'b0, 1'b1, 32'h0000_00FF, 1'b0);
      tbl[14] = mk(3'b110, 32'h0000_0101, 32'hA5A5_5A5A, 3'd1, 5'd15, 1'b1, 1'b1, 32'hA5A5_5A5A, 1'b1);
      tbl[15] = mk(3'b000, 32'h0000_0100, 32'h0000_007F, 3'd1, 5'd1,  1'b1, 1'b1, 32'h0000_007F, 1'b1);

      // Reset state
      idle_in();
      en = 1'b0;
      RST = 1'b1;
      #2;
      chk("rst_regwr", regWr_o, 32'd0);
      chk("rst_rd", rd_o, 32'd0);
      chk("rst_wdat", wdat_o, 32'd0);
      chk("rst_halt", halt_o, 32'd0);
      chk("rst_stall", mem_stall, 32'd0);
      #10;
      RST = 1'b0;
      tick();

      // Single-cycle hit vectors through the scoreboard
      for (int i = 0; i < NV; i++) begin
         idle_in();
         func3_i = tbl[i].func3; port_out_i = tbl[i].addr; dmemload = tbl[i].load;
         rdSel_i = tbl[i].rdsel; rd_i = tbl[i].rd; regWr_i = tbl[i].regwr;
         dREN_i = tbl[i].ren; dhit = tbl[i].ren;
         sb.push_back({tbl[i].exp_regwr, tbl[i].rd, tbl[i].exp_wdat});
         #1;
         chk($sformatf("v%0d_stall", i), mem_stall, 32'd0);
         chk($sformatf("v%0d_ren", i), dmemREN, tbl[i].ren);
         chk($sformatf("v%0d_addr", i), dmemaddr, {tbl[i].addr[31:2], 2'b00});
         tick();
         e = sb.pop_front();
         chk($sformatf("v%0d_wdat", i), wdat_o, e[31:0]);
         chk($sformatf("v%0d_rd", i), rd_o, e[36:32]);
         chk($sformatf("v%0d_regwr", i), regWr_o, e[37]);
      end

      // LB miss for three cycles, then hit
      idle_in();
      func3_i = 3'b000; port_out_i = 32'h0000_0103; dmemload = 32'h80FF_1234;
      rdSel_i = 3'd1; rd_i = 5'd4; regWr_i = 1'b1; dREN_i = 1'b1; dhit = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("miss_stall", mem_stall, 32'd1);
         chk("miss_ren", dmemREN, 32'd1);
         tick();
         chk("miss_hold_wdat", wdat_o, 32'h0000_007F);
      end
      dhit = 1'b1;
      #1;
      chk("miss_hit_stall", mem_stall, 32'd0);
      tick();
      chk("miss_lb_wdat", wdat_o, 32'hFFFF_FF80);
      chk("miss_lb_rd", rd_o, 32'd4);

      // Store hit while en=0: single write cycle, then HELD until en
      idle_in();
      dWEN_i = 1'b1; port_out_i = 32'h0000_020B; rdat2_i = 32'hCAFE_F00D;
      dhit = 1'b1; en = 1'b0;
      #1;
      chk("sw_wen", dmemWEN, 32'd1);
      chk("sw_ren", dmemREN, 32'd0);
      chk("sw_addr", dmemaddr, 32'h0000_0208);
      chk("sw_data", dmemstore, 32'hCAFE_F00D);
      tick();
      chk("held_wen", dmemWEN, 32'd0);
      chk("held_stall", mem_stall, 32'd0);
      tick();
      chk("held_wen2", dmemWEN, 32'd0);
      en = 1'b1;
      tick();
      chk("sw_wdat", wdat_o, 32'h0000_020B);
      chk("sw_regwr", regWr_o, 32'd0);
      chk("idle_wen", dmemWEN, 32'd1);

      // Load hit while en=0: buffered data used once en returns
      idle_in();
      dREN_i = 1'b1; port_out_i = 32'h0000_0300; dmemload = 32'h1111_2222;
      rdSel_i = 3'd1; rd_i = 5'd7; regWr_i = 1'b1; dhit = 1'b1; en = 1'b0;
      tick();
      dmemload = 32'h9999_9999; dhit = 1'b0;
      #1;
      chk("hld_stall", mem_stall, 32'd0);
      chk("hld_ren", dmemREN, 32'd0);
      en = 1'b1;
      tick();
      chk("hld_wdat", wdat_o, 32'h1111_2222);
      chk("hld_rd", rd_o, 32'd7);

      // Flush while a miss is outstanding
      idle_in();
      dREN_i = 1'b1; port_out_i = 32'h0000_0400; rdSel_i = 3'd1;
      rd_i = 5'd9; regWr_i = 1'b1; dhit = 1'b0;
      #1;
      chk("fl_busy_stall", mem_stall, 32'd1);
      tick();
      flush = 1'b1;
      #1;
      chk("fl_ren", dmemREN, 32'd0);
      chk("fl_stall", mem_stall, 32'd0);
      tick();
      chk("fl_regwr", regWr_o, 32'd0);
      chk("fl_rd", rd_o, 32'd0);
      chk("fl_wdat", wdat_o, 32'd0);

      // Sticky halt
      idle_in();
      halt_i = 1'b1; flush = 1'b1;
      tick();
      chk("halt_flushed", halt_o, 32'd0);
      flush = 1'b0;
      tick();
      chk("halt_set", halt_o, 32'd1);
      halt_i = 1'b0; flush = 1'b1;
      tick();
      chk("halt_after_flush", halt_o, 32'd1);
      flush = 1'b0; port_out_i = 32'h0000_0500; rd_i = 5'd3; regWr_i = 1'b1;
      tick();
      chk("halt_after_instr", halt_o, 32'd1);
      chk("pre_rst_wdat", wdat_o, 32'h0000_0500);

      // Reset during an outstanding miss
      dREN_i = 1'b1; rdSel_i = 3'd1; dhit = 1'b0;
      #1;
      chk("rb_stall", mem_stall, 32'd1);
      tick();
      RST = 1'b1;
      #1;
      chk("rb_ren", dmemREN, 32'd0);
      chk("rb_stall0", mem_stall, 32'd0);
      chk("rb_wdat", wdat_o, 32'd0);
      chk("rb_regwr", regWr_o, 32'd0);
      chk("rb_halt", halt_o, 32'd0);
      dREN_i = 1'b0;
      tick();
      RST = 1'b0;
      tick();
      chk("rb_noreq", dmemREN, 32'd0);
      dREN_i = 1'b1; dhit = 1'b1;
      #1;
      chk("rb_newreq", dmemREN, 32'd1);
      tick();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
